apb3_waitstate_slave: RTL and testbench
=======================================

APB3_WAITSTATE_SLAVE -- requirements
Module: apb3_waitstate_slave

Interface
REQ-001 SHALL have parameter ADDR_LSB_W, default 8, giving the number of PADDR bits decoded.
REQ-002 SHALL have parameter RST_WAIT, default 0, giving the reset value of CTRL.WAIT.
REQ-003 SHALL use one clock and an asynchronous, active-high reset.
REQ-004 SHALL have port PCLK, input, 1 bit: the single clock; all state is on the rising edge.
REQ-005 SHALL have port PRESET, input, 1 bit: asynchronous, active-high reset.
REQ-006 SHALL have port PSEL, input, 1 bit: slave select from the bridge.
REQ-007 SHALL have port PENABLE, input, 1 bit: APB access phase.
REQ-008 SHALL have port PWRITE, input, 1 bit: 1 = write.
REQ-009 SHALL have port PADDR, input, 32 bits: byte address; only [ADDR_LSB_W-1:0] is decoded.
REQ-010 SHALL have port PWDATA, input, 32 bits: write data.
REQ-011 SHALL have port PRDATA, output, 32 bits: read data; valid only while PREADY=1, else 0.
REQ-012 SHALL have port PREADY, output, 1 bit: transfer completes this cycle.
REQ-013 SHALL have port PSLVERR, output, 1 bit: error response; meaningful only while PREADY=1, else 0.
REQ-014 SHALL have port INT, output, 1 bit: level interrupt.

Function
REQ-015 SHALL implement the following register map:
- 0x00 CTRL (RW): [3:0] WAIT, [4] INT_EN.
- 0x04 STATUS (W1C): [0] WRAP, [1] ERR.
- 0x08 COUNT (RO): [15:0] count of completed non-error transfers.
- 0x10/0x14/0x18/0x1C SCRATCH0-3 (RW, 32-bit).
- Unused bits read 0.
REQ-016 SHALL implement an FSM with states IDLE, WAIT and DONE.
REQ-017 SHALL go IDLE -> WAIT on PSEL=1 & PENABLE=0 (setup phase), loading the wait counter with CTRL.WAIT.
REQ-018 SHALL stay in WAIT while PSEL & PENABLE and the counter is nonzero, decrementing the counter each cycle.
REQ-019 SHALL assert PREADY combinationally in WAIT when the counter = 0 and PSEL & PENABLE; the next state is DONE.
REQ-020 SHALL go DONE -> IDLE unconditionally; a setup phase seen in DONE SHALL be treated as in IDLE (back-to-back transfers).
REQ-021 SHALL give latency as follows: WAIT=0 completes in the first access cycle (zero wait states); WAIT=N inserts exactly N PREADY-low access cycles.
REQ-022 SHALL return to IDLE if PSEL drops while in WAIT (abort), with no register write, no COUNT change, and no PREADY.
REQ-023 SHALL commit writes only on the cycle with PSEL & PENABLE & PREADY & PWRITE & ~PSLVERR.
REQ-024 SHALL raise PSLVERR with PREADY, and suppress the write, when:
- PADDR[1:0] != 0;
- the offset is not in the register map; or
- the transfer is a write to COUNT.
REQ-025 SHALL increment COUNT (modulo 2^16) on every completed transfer with PSLVERR=0; when 0xFFFF wraps to 0, SHALL set STATUS.WRAP.
REQ-026 SHALL set STATUS.ERR on every completed transfer with PSLVERR=1.
REQ-027 SHALL clear STATUS bits written with 1; if a set and a W1C hit the same bit in the same cycle, set SHALL win.
REQ-028 SHALL make a CTRL.WAIT write take effect from the next setup phase, never the current transfer.
REQ-029 SHALL drive INT = CTRL.INT_EN & (STATUS.WRAP | STATUS.ERR), registered (one cycle after the status change).

Reset
REQ-030 SHALL, on PRESET=1 and independent of PCLK:
- set the FSM to IDLE and PREADY, PSLVERR, PRDATA and INT to 0;
- set CTRL to {INT_EN=0, WAIT=RST_WAIT}, and STATUS, COUNT and SCRATCH0-3 to 0.
REQ-031 SHALL abandon any transfer in progress when reset is asserted mid-transfer, leaving no partial write; the first transfer after reset release SHALL behave as from IDLE.

Structure
REQ-032 SHALL place register offsets, field positions, the FSM state enum, and the COUNT and WAIT widths in shared package apb3_waitstate_pkg.
REQ-033 SHALL implement the wait counter (load, decrement, zero flag) as one sub-module, apb_wait_ctr; all other logic SHALL be in the top module.

Verification
REQ-034 SHALL cover: reset, then read CTRL, WAIT=0 -> PREADY in the first access cycle, PRDATA=0x00000000|RST_WAIT, PSLVERR=0.
REQ-035 SHALL cover: write CTRL=0x13, then write SCRATCH2=0xA5A5_5A5A and read it back -> exactly 3 PREADY-low access cycles on each, read data 0xA5A5_5A5A, COUNT=3.
REQ-036 SHALL cover: write 0x08, then read 0x22 and 0x40 -> three PSLVERR=1 responses, COUNT unchanged, STATUS=0x2, INT=1 one cycle later; then write STATUS=0x2 -> INT=0.
REQ-037 SHALL cover: with WAIT=5, drop PSEL in the 2nd access cycle of a SCRATCH0 write -> no PREADY, SCRATCH0 and COUNT unchanged, next transfer normal.
REQ-038 SHALL cover: preload COUNT to 0xFFFE via 0xFFFE good transfers (or force), then do 2 reads -> COUNT=0x0000, STATUS.WRAP=1; a W1C of WRAP in the same cycle as the wrap -> WRAP stays 1.
REQ-039 SHALL cover: assert PRESET during WAIT of a SCRATCH1 write with WAIT=4 -> PREADY=0 immediately, SCRATCH1=0, CTRL.WAIT=RST_WAIT after release.

Source files
------------

// File: rtl/apb3_waitstate_pkg.sv
// Shared definitions for the APB3 wait-state slave: register map, field positions,
// FSM states and register layouts.
package apb3_waitstate_pkg;

  localparam int unsigned ADDR_W      = 32;
  localparam int unsigned DATA_W      = 32;
  localparam int unsigned WAIT_W      = 4;
  localparam int unsigned COUNT_W     = 16;
  localparam int unsigned NUM_SCRATCH = 4;
  localparam int unsigned SCR_IDX_W   = $clog2(NUM_SCRATCH);

  localparam logic [7:0] OFF_CTRL     = 8'h00;
  localparam logic [7:0] OFF_STATUS   = 8'h04;
  localparam logic [7:0] OFF_COUNT    = 8'h08;
  localparam logic [7:0] OFF_SCRATCH0 = 8'h10;
  localparam logic [7:0] OFF_SCRATCH1 = 8'h14;
  localparam logic [7:0] OFF_SCRATCH2 = 8'h18;
  localparam logic [7:0] OFF_SCRATCH3 = 8'h1C;

  localparam int unsigned CTRL_WAIT_LSB   = 0;
  localparam int unsigned CTRL_INT_EN_BIT = 4;
  localparam int unsigned STATUS_WRAP_BIT = 0;
  localparam int unsigned STATUS_ERR_BIT  = 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Packed layouts match the bit positions seen on the bus
  typedef struct packed {
    logic              int_en;
    logic [WAIT_W-1:0] wait_cyc;
  } ctrl_t;

  typedef struct packed {
    logic err;
    logic wrap;
  } status_t;

endpackage

// File: rtl/apb3_waitstate_slave_if.sv
// APB3 bus bundle between a bridge (master) and the wait-state slave.
interface apb3_waitstate_slave_if;
  import apb3_waitstate_pkg::*;

  logic              PSEL;
  logic              PENABLE;
  logic              PWRITE;
  logic [ADDR_W-1:0] PADDR;
  logic [DATA_W-1:0] PWDATA;
  logic [DATA_W-1:0] PRDATA;
  logic              PREADY;
  logic              PSLVERR;
  logic              INT;

  modport master (
    output PSEL, PENABLE, PWRITE, PADDR, PWDATA,
    input  PRDATA, PREADY, PSLVERR, INT
  );

  modport slave (
    input  PSEL, PENABLE, PWRITE, PADDR, PWDATA,
    output PRDATA, PREADY, PSLVERR, INT
  );

endinterface

// File: rtl/apb_wait_ctr.sv
// Wait-state down-counter: loaded at setup, decremented per stalled access cycle,
// with a registered zero flag so the ready decision needs no compare.
module apb_wait_ctr
  import apb3_waitstate_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              load_i,
  input  logic [WAIT_W-1:0] load_val_i,
  input  logic              dec_i,
  output logic              zero_o
);

  logic [WAIT_W-1:0] cnt_q, cnt_d;
  logic              zero_q, zero_d;

  always_comb begin
    cnt_d  = cnt_q;
    zero_d = zero_q;
    if (load_i) begin
      cnt_d  = load_val_i;
      zero_d = (load_val_i == '0);
    end else if (dec_i && !zero_q) begin
      cnt_d  = cnt_q - WAIT_W'(1);
      zero_d = (cnt_q == WAIT_W'(1));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q  <= '0;
      zero_q <= 1'b1;
    end else begin
      cnt_q  <= cnt_d;
      zero_q <= zero_d;
    end
  end

  assign zero_o = zero_q;

endmodule

// File: rtl/apb3_waitstate_slave.sv
// APB3 register slave with programmable wait states, transfer counter,
// sticky status and level interrupt.
module apb3_waitstate_slave
  import apb3_waitstate_pkg::*;
#(
  parameter int unsigned ADDR_LSB_W = 8,
  parameter int unsigned RST_WAIT   = 0
) (
  input  logic                   PCLK,
  input  logic                   PRESET,
  apb3_waitstate_slave_if.slave  apb
);

  state_e                    state_q;
  ctrl_t                     ctrl_q, ctrl_d;
  status_t                   status_q, status_d;
  logic [COUNT_W-1:0]        count_q, count_d;
  logic                      int_q, int_d;
  logic [DATA_W-1:0]         scratch_q [NUM_SCRATCH];

  logic [ADDR_LSB_W-1:0]     off;
  logic [SCR_IDX_W-1:0]      scr_idx;
  logic                      hit_ctrl, hit_status, hit_count, hit_scr;
  logic                      map_hit, misalign, bad_c;
  logic [DATA_W-1:0]         rdata_c;
  logic                      setup_c, access_c, pready_c, pslverr_c;
  logic                      wr_commit_c, ok_done_c, err_done_c;
  logic                      ctr_load_c, ctr_dec_c, ctr_zero;

  assign off      = apb.PADDR[ADDR_LSB_W-1:0];
  assign scr_idx  = off[SCR_IDX_W+1:2];
  assign misalign = |off[1:0];

  generate
    if (ADDR_LSB_W < ADDR_W) begin : g_unused_paddr
      logic unused_paddr;
      assign unused_paddr = ^apb.PADDR[ADDR_W-1:ADDR_LSB_W];
    end
  endgenerate

  // Address decode and read mux
  always_comb begin
    hit_ctrl   = 1'b0;
    hit_status = 1'b0;
    hit_count  = 1'b0;
    hit_scr    = 1'b0;
    rdata_c    = '0;
    case (off)
      ADDR_LSB_W'(OFF_CTRL): begin
        hit_ctrl = 1'b1;
        rdata_c  = DATA_W'(ctrl_q);
      end
      ADDR_LSB_W'(OFF_STATUS): begin
        hit_status = 1'b1;
        rdata_c    = DATA_W'(status_q);
      end
      ADDR_LSB_W'(OFF_COUNT): begin
        hit_count = 1'b1;
        rdata_c   = DATA_W'(count_q);
      end
      ADDR_LSB_W'(OFF_SCRATCH0), ADDR_LSB_W'(OFF_SCRATCH1),
      ADDR_LSB_W'(OFF_SCRATCH2), ADDR_LSB_W'(OFF_SCRATCH3): begin
        hit_scr = 1'b1;
        rdata_c = scratch_q[scr_idx];
      end
      default: ;
    endcase
  end

  assign map_hit = hit_ctrl | hit_status | hit_count | hit_scr;
  assign bad_c   = misalign | ~map_hit | (hit_count & apb.PWRITE);

  assign setup_c     = apb.PSEL & ~apb.PENABLE;
  assign access_c    = apb.PSEL & apb.PENABLE;
  assign pready_c    = (state_q == ST_WAIT) & access_c & ctr_zero;
  assign pslverr_c   = pready_c & bad_c;
  assign ok_done_c   = pready_c & ~bad_c;
  assign err_done_c  = pslverr_c;
  assign wr_commit_c = ok_done_c & apb.PWRITE;

  // A setup phase seen in any state (re)arms the counter with the current WAIT
  assign ctr_load_c = setup_c;
  assign ctr_dec_c  = (state_q == ST_WAIT) & access_c & ~ctr_zero;

  apb_wait_ctr u_wait_ctr (
    .clk        (PCLK),
    .rst        (PRESET),
    .load_i     (ctr_load_c),
    .load_val_i (ctrl_q.wait_cyc),
    .dec_i      (ctr_dec_c),
    .zero_o     (ctr_zero)
  );

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      state_q <= ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE, ST_DONE: state_q <= setup_c ? ST_WAIT : ST_IDLE;
        ST_WAIT: begin
          if (!apb.PSEL)         state_q <= ST_IDLE;
          else if (!apb.PENABLE) state_q <= ST_WAIT;
          else if (ctr_zero)     state_q <= ST_DONE;
          else                   state_q <= ST_WAIT;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Register updates; hardware set of a status bit overrides a same-cycle W1C
  always_comb begin
    ctrl_d   = ctrl_q;
    status_d = status_q;
    count_d  = count_q;
    int_d    = ctrl_q.int_en & (status_q.wrap | status_q.err);
    if (wr_commit_c && hit_ctrl) begin
      ctrl_d.wait_cyc = apb.PWDATA[CTRL_WAIT_LSB +: WAIT_W];
      ctrl_d.int_en   = apb.PWDATA[CTRL_INT_EN_BIT];
    end
    if (wr_commit_c && hit_status) begin
      if (apb.PWDATA[STATUS_WRAP_BIT]) status_d.wrap = 1'b0;
      if (apb.PWDATA[STATUS_ERR_BIT])  status_d.err  = 1'b0;
    end
    if (ok_done_c) begin
      count_d = count_q + COUNT_W'(1);
      if (count_q == '1) status_d.wrap = 1'b1;
    end
    if (err_done_c) status_d.err = 1'b1;
  end

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      ctrl_q   <= '{int_en: 1'b0, wait_cyc: WAIT_W'(RST_WAIT)};
      status_q <= '0;
      count_q  <= '0;
      int_q    <= 1'b0;
    end else begin
      ctrl_q   <= ctrl_d;
      status_q <= status_d;
      count_q  <= count_d;
      int_q    <= int_d;
    end
  end

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      for (int i = 0; i < NUM_SCRATCH; i++) scratch_q[i] <= '0;
    end else if (wr_commit_c && hit_scr) begin
      scratch_q[scr_idx] <= apb.PWDATA;
    end
  end

  assign apb.PREADY  = pready_c;
  assign apb.PSLVERR = pslverr_c;
  assign apb.PRDATA  = (pready_c & ~apb.PWRITE & ~bad_c) ? rdata_c : '0;
  assign apb.INT     = int_q;

endmodule

// File: tb/tb_apb3_waitstate_slave.sv
// Self-checking bench: directed scenarios plus random APB traffic checked
// against a register-level reference model.
module tb_apb3_waitstate_slave;

  localparam int unsigned ADDR_LSB_W = 8;
  localparam int unsigned RST_WAIT   = 0;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;

  apb3_waitstate_slave_if bus ();

  apb3_waitstate_slave #(
    .ADDR_LSB_W (ADDR_LSB_W),
    .RST_WAIT   (RST_WAIT)
  ) dut (
    .PCLK   (clk),
    .PRESET (rst),
    .apb    (bus)
  );

  always #5 clk = ~clk;

  // Reference model state
  logic [3:0]  m_wait;
  logic        m_int_en;
  logic        m_wrap;
  logic        m_err;
  logic [15:0] m_count;
  logic [31:0] m_scr [4];

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_wait   = 4'(RST_WAIT);
    m_int_en = 1'b0;
    m_wrap   = 1'b0;
    m_err    = 1'b0;
    m_count  = 16'd0;
    for (int i = 0; i < 4; i++) m_scr[i] = 32'd0;
  endtask

  function automatic bit model_is_err(input int off, input logic wr);
    bit mapped;
    mapped = (off == 0) || (off == 4) || (off == 8) || (off == 16) ||
             (off == 20) || (off == 24) || (off == 28);
    return (off % 4 != 0) || !mapped || (wr && off == 8);
  endfunction

  function automatic logic [31:0] model_read(input int off);
    case (off)
      0:              return {27'd0, m_int_en, m_wait};
      4:              return {30'd0, m_err, m_wrap};
      8:              return {16'd0, m_count};
      16, 20, 24, 28: return m_scr[(off - 16) / 4];
      default:        return 32'd0;
    endcase
  endfunction

  task automatic model_commit(input int off, input logic wr, input logic [31:0] wd, input bit err);
    if (err) begin
      m_err = 1'b1;
    end else begin
      if (wr) begin
        case (off)
          0: begin m_wait = wd[3:0]; m_int_en = wd[4]; end
          4: begin if (wd[0]) m_wrap = 1'b0; if (wd[1]) m_err = 1'b0; end
          16, 20, 24, 28: m_scr[(off - 16) / 4] = wd;
          default: ;
        endcase
      end
      m_count = m_count + 16'd1;
      if (m_count == 16'd0) m_wrap = 1'b1;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      bus.PSEL    = 1'b0;
      bus.PENABLE = 1'b0;
    end
  endtask

  task automatic chk_int(input string tag);
    idle(2);
    #1 chk(tag, 32'(bus.INT), 32'(m_int_en & (m_wrap | m_err)));
  endtask

  // One transfer; abort_cyc>0 drops PSEL (or asserts reset) in that access cycle
  task automatic xfer(input logic [31:0] addr, input logic wr, input logic [31:0] wd,
                      input int abort_cyc, input bit abort_rst);
    int          off;
    int          exp_waits;
    bit          exp_err;
    logic [31:0] exp_rd;
    off       = int'(addr[ADDR_LSB_W-1:0]);
    exp_err   = model_is_err(off, wr);
    exp_waits = int'(m_wait);
    exp_rd    = model_read(off);
    @(negedge clk);
    bus.PSEL    = 1'b1;
    bus.PENABLE = 1'b0;
    bus.PADDR   = addr;
    bus.PWRITE  = wr;
    bus.PWDATA  = wd;
    #1 chk("setup_ready", 32'(bus.PREADY), 32'd0);
    for (int c = 1; c <= exp_waits + 1; c++) begin
      @(negedge clk);
      if (c == abort_cyc) begin
        if (abort_rst) begin
          bus.PENABLE = 1'b1;
          rst = 1'b1;
          #1;
          chk("rst_ready", 32'(bus.PREADY), 32'd0);
          chk("rst_slverr", 32'(bus.PSLVERR), 32'd0);
          chk("rst_prdata", bus.PRDATA, 32'd0);
          chk("rst_int", 32'(bus.INT), 32'd0);
          idle(1);
          @(negedge clk);
          rst = 1'b0;
          model_reset();
        end else begin
          bus.PSEL    = 1'b0;
          bus.PENABLE = 1'b0;
          #1 chk("abort_ready", 32'(bus.PREADY), 32'd0);
        end
        return;
      end
      bus.PENABLE = 1'b1;
      #1;
      if (c <= exp_waits) begin
        chk("wait_ready", 32'(bus.PREADY), 32'd0);
        chk("wait_slverr", 32'(bus.PSLVERR), 32'd0);
        chk("wait_prdata", bus.PRDATA, 32'd0);
      end else begin
        chk("done_ready", 32'(bus.PREADY), 32'd1);
        chk("done_slverr", 32'(bus.PSLVERR), 32'(exp_err));
        chk("done_prdata", bus.PRDATA, (wr || exp_err) ? 32'd0 : exp_rd);
        model_commit(off, wr, wd, exp_err);
      end
    end
  endtask

  task automatic rd(input logic [31:0] addr);
    xfer(addr, 1'b0, 32'd0, 0, 1'b0);
  endtask

  task automatic wr(input logic [31:0] addr, input logic [31:0] wd);
    xfer(addr, 1'b1, wd, 0, 1'b0);
  endtask

  task automatic force_count(input logic [15:0] val);
    idle(1);
    force dut.count_q = val;
    @(negedge clk);
    release dut.count_q;
    m_count = val;
  endtask

  initial begin
    int valid_off [7] = '{0, 4, 8, 16, 20, 24, 28};
    bus.PSEL    = 1'b0;
    bus.PENABLE = 1'b0;
    bus.PWRITE  = 1'b0;
    bus.PADDR   = 32'd0;
    bus.PWDATA  = 32'd0;
    model_reset();

    // Reset state
    repeat (3) @(negedge clk);
    #1;
    chk("reset_ready", 32'(bus.PREADY), 32'd0);
    chk("reset_slverr", 32'(bus.PSLVERR), 32'd0);
    chk("reset_prdata", bus.PRDATA, 32'd0);
    chk("reset_int", 32'(bus.INT), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Reset value of CTRL, zero wait states
    rd(32'h0000_0000);
    idle(1);

    // WAIT=3 with INT_EN, scratch write/read round trip, back-to-back
    wr(32'h0000_0000, 32'h0000_0013);
    wr(32'h0000_0018, 32'hA5A5_5A5A);
    rd(32'h0000_0018);
    rd(32'h0000_0008);
    chk_int("int_after_good");

    // Error responses and delayed interrupt
    wr(32'h0000_0008, 32'h0000_1234);
    idle(1);
    #1 chk("int_lag0", 32'(bus.INT), 32'd0);
    @(negedge clk);
    #1 chk("int_lag1", 32'(bus.INT), 32'd1);
    rd(32'h0000_0022);
    rd(32'h0000_0040);
    rd(32'h0000_0008);
    rd(32'h0000_0004);
    wr(32'h0000_0004, 32'h0000_0002);
    chk_int("int_cleared");

    // Abort in the second access cycle of a WAIT=5 write
    wr(32'h0000_0000, 32'h0000_0015);
    xfer(32'h0000_0010, 1'b1, 32'hDEAD_BEEF, 2, 1'b0);
    rd(32'h0000_0010);
    rd(32'h0000_0008);
    idle(1);

    // COUNT wrap and set-wins-over-W1C
    wr(32'h0000_0000, 32'h0000_0010);
    force_count(16'hFFFE);
    rd(32'h0000_0000);
    rd(32'h0000_0000);
    rd(32'h0000_0008);
    rd(32'h0000_0004);
    chk("wrap_model", 32'(m_wrap), 32'd1);
    wr(32'h0000_0004, 32'h0000_0003);
    rd(32'h0000_0004);
    force_count(16'hFFFF);
    wr(32'h0000_0004, 32'h0000_0001);
    rd(32'h0000_0004);
    chk_int("int_wrap");

    // Random traffic
    for (int n = 0; n < 250; n++) begin
      int          sel;
      int          off;
      logic        w;
      logic [31:0] wd;
      logic [31:0] addr;
      int          ab;
      sel = int'($urandom_range(0, 9));
      if (sel < 7)       off = valid_off[sel];
      else if (sel == 7) off = valid_off[$urandom_range(0, 6)] + int'($urandom_range(1, 3));
      else if (sel == 8) off = ($urandom_range(0, 3) == 0) ? 12 : 4 * int'($urandom_range(8, 63));
      else               off = int'($urandom_range(0, 255));
      addr = ($urandom & 32'hFFFF_FF00) | 32'(off);
      w    = 1'($urandom_range(0, 1));
      wd   = $urandom;
      if (off == 0) wd[3:0] = 4'($urandom_range(0, 7));
      ab = ($urandom_range(0, 9) == 0) ? int'($urandom_range(1, int'(m_wait) + 1)) : 0;
      xfer(addr, w, wd, ab, 1'b0);
      case ($urandom_range(0, 3))
        0: chk_int("int_rand");
        1: idle(1);
        default: ;
      endcase
    end

    // Reset in the middle of a WAIT=4 scratch write
    idle(1);
    wr(32'h0000_0000, 32'h0000_0004);
    xfer(32'h0000_0014, 1'b1, 32'h1357_9BDF, 2, 1'b1);
    rd(32'h0000_0014);
    rd(32'h0000_0000);
    rd(32'h0000_0008);
    chk_int("int_post_reset");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
